// File: rtl/trng_collector.sv
// TRNG bit collector: decimates the synchronised ring-oscillator stream, optionally
// applies von Neumann debiasing, and packs bits MSB-first into words on a valid/ready port.
module trng_collector #(
  parameter int WORD_W = 32,
  parameter int SMPL_W = 16
) (
  input  logic              rng_clk,
  input  logic              rst_n,
  input  logic              collect_en,
  input  logic [SMPL_W-1:0] sample_cnt,
  input  logic              vn_bypass,
  input  logic              sync_valid,
  input  logic              sync_data,
  input  logic              word_ready,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              overflow
);

  localparam int CNT_W = $clog2(WORD_W);

  typedef enum logic {VN_IDLE, VN_HAVE} vn_state_t;

  logic [SMPL_W-1:0] smp_cnt_q, smp_cnt_d;
  vn_state_t         vn_state_q, vn_state_d;
  logic              vn_bit_q, vn_bit_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              word_valid_q, word_valid_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic              overflow_q, overflow_d;

  logic              active;
  logic [SMPL_W-1:0] period;
  logic              strobe;
  logic              emit;
  logic              emit_bit;
  logic [WORD_W-1:0] shifted;
  logic              complete;
  logic              xfer;

  // Sample decimation: a zero period behaves as one so the strobe can never stall.
  always_comb begin
    active    = collect_en && sync_valid;
    period    = (sample_cnt == '0) ? SMPL_W'(1) : sample_cnt;
    strobe    = active && (smp_cnt_q == period - SMPL_W'(1));
    smp_cnt_d = smp_cnt_q + SMPL_W'(1);
    if (!active || strobe) begin
      smp_cnt_d = '0;
    end
  end

  always_comb begin
    vn_state_d = vn_state_q;
    vn_bit_d   = vn_bit_q;
    emit       = 1'b0;
    emit_bit   = sync_data;
    if (!collect_en || vn_bypass) begin
      vn_state_d = VN_IDLE;
      emit       = strobe;
    end else if (strobe) begin
      case (vn_state_q)
        VN_IDLE: begin
          vn_bit_d   = sync_data;
          vn_state_d = VN_HAVE;
        end
        default: begin
          // Pair 10 emits 1, pair 01 emits 0: the first bit of an unequal pair.
          emit       = (vn_bit_q != sync_data);
          emit_bit   = vn_bit_q;
          vn_state_d = VN_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    shifted   = {shreg_q[WORD_W-2:0], emit_bit};
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    complete  = 1'b0;
    if (!collect_en) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (emit) begin
      if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
        complete  = 1'b1;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end else begin
        shreg_d   = shifted;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // Holding register: a completed word is dropped only when the slot is full and not draining.
  always_comb begin
    xfer         = word_valid_q && word_ready;
    word_valid_d = word_valid_q && !xfer;
    word_data_d  = word_data_q;
    overflow_d   = overflow_q;
    if (complete) begin
      if (!word_valid_q || xfer) begin
        word_valid_d = 1'b1;
        word_data_d  = shifted;
      end else begin
        overflow_d = 1'b1;
      end
    end
    if (!collect_en) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_q    <= '0;
      vn_state_q   <= VN_IDLE;
      vn_bit_q     <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      smp_cnt_q    <= smp_cnt_d;
      vn_state_q   <= vn_state_d;
      vn_bit_q     <= vn_bit_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      overflow_q   <= overflow_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: a vector table for the decimation/debias paths
// plus hand-written sequences for overflow, sync gaps, simultaneous events and async reset.
module tb_trng_collector;

  logic        rng_clk = 1'b0;
  logic        rst_n;
  logic        collect_en;
  logic [15:0] sample_cnt;
  logic        vn_bypass;
  logic        sync_valid;
  logic        sync_data;
  logic        word_ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  trng_collector #(.WORD_W(32), .SMPL_W(16)) dut (
    .rng_clk    (rng_clk),
    .rst_n      (rst_n),
    .collect_en (collect_en),
    .sample_cnt (sample_cnt),
    .vn_bypass  (vn_bypass),
    .sync_valid (sync_valid),
    .sync_data  (sync_data),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word_data  (word_data),
    .overflow   (overflow)
  );

  always #5 rng_clk = ~rng_clk;

  typedef struct {
    logic        vn_bypass;
    logic [15:0] sc;
    logic [31:0] pattern;   // per-sample bit stream, repeated cyclically, MSB first
    logic [31:0] exp_word;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic feed_word(input logic [31:0] w, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      sync_data = w[31-b];
      tick();
    end
  endtask

  task automatic flush();
    collect_en = 1'b0;
    word_ready = 1'b1;
    sync_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] w[3];
    logic [31:0] pat;
    int          period;
    int          cyc;
    bit          got;

    vecs[0] = '{1'b1, 16'd1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32};
    vecs[1] = '{1'b1, 16'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 128};
    vecs[2] = '{1'b1, 16'd0, 32'h12345678, 32'h12345678, 32};
    vecs[3] = '{1'b0, 16'd1, 32'h63636363, 32'h55555555, 124};
    vecs[4] = '{1'b0, 16'd2, 32'h99999999, 32'hAAAAAAAA, 128};
    vecs[5] = '{1'b1, 16'd3, 32'hDEADBEEF, 32'hDEADBEEF, 96};

    rst_n = 1'b0; collect_en = 1'b0; sample_cnt = 16'd1; vn_bypass = 1'b1;
    sync_valid = 1'b0; sync_data = 1'b0; word_ready = 1'b0;
    #22 rst_n = 1'b1;
    tick();
    check("reset word_valid", 32'(word_valid), 32'd0);
    check("reset word_data", word_data, 32'h0);
    check("reset overflow", 32'(overflow), 32'd0);

    for (int v = 0; v < 6; v++) begin
      flush();
      vn_bypass  = vecs[v].vn_bypass;
      sample_cnt = vecs[v].sc;
      pat        = vecs[v].pattern;
      period     = (vecs[v].sc == 16'd0) ? 1 : int'(vecs[v].sc);
      collect_en = 1'b1;
      sync_valid = 1'b1;
      got = 1'b0;
      cyc = 0;
      for (int c = 0; c < 400 && !got; c++) begin
        sync_data = pat[31 - ((c / period) % 32)];
        tick();
        if (word_valid) begin
          got = 1'b1;
          cyc = c + 1;
        end
      end
      check($sformatf("vec%0d latency", v), 32'(cyc), 32'(vecs[v].exp_cycles));
      check($sformatf("vec%0d word", v), word_data, vecs[v].exp_word);
      check($sformatf("vec%0d overflow", v), 32'(overflow), 32'd0);
      sync_valid = 1'b0;
      tick();
      check($sformatf("vec%0d valid drop", v), 32'(word_valid), 32'd0);
    end

    // Overflow with consumer stalled, cleared by a one-cycle collect_en low.
    flush();
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333;
    word_ready = 1'b0; vn_bypass = 1'b1; sample_cnt = 16'd1;
    collect_en = 1'b1; sync_valid = 1'b1;
    feed_word(w[0], 32);
    check("ovf first valid", 32'(word_valid), 32'd1);
    check("ovf first word", word_data, w[0]);
    check("ovf not yet", 32'(overflow), 32'd0);
    feed_word(w[1], 32);
    check("ovf set", 32'(overflow), 32'd1);
    check("ovf held word", word_data, w[0]);
    feed_word(w[2], 32);
    check("ovf held word 3", word_data, w[0]);
    collect_en = 1'b0;
    tick();
    check("ovf cleared", 32'(overflow), 32'd0);
    check("ovf valid kept", 32'(word_valid), 32'd1);
    check("ovf word kept", word_data, w[0]);
    word_ready = 1'b1;
    tick();
    check("ovf transfer drop", 32'(word_valid), 32'd0);

    // sync_valid gap keeps the partial word.
    flush();
    pat = 32'hCAFEF00D;
    collect_en = 1'b1; sync_valid = 1'b1;
    for (int b = 0; b < 10; b++) begin
      sync_data = pat[31-b];
      tick();
    end
    sync_valid = 1'b0;
    sync_data  = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("gap no word", 32'(word_valid), 32'd0);
    sync_valid = 1'b1;
    for (int b = 10; b < 31; b++) begin
      sync_data = pat[31-b];
      tick();
    end
    check("gap not early", 32'(word_valid), 32'd0);
    sync_data = pat[0];
    tick();
    check("gap valid", 32'(word_valid), 32'd1);
    check("gap word", word_data, pat);

    // Transfer and completion in the same cycle load the new word without overflow.
    flush();
    word_ready = 1'b0; collect_en = 1'b1; sync_valid = 1'b1;
    feed_word(32'h0BADF00D, 32);
    feed_word(32'h600DCAFE, 31);
    sync_data  = 1'b0;
    word_ready = 1'b1;
    tick();
    check("simul valid", 32'(word_valid), 32'd1);
    check("simul word", word_data, 32'h600DCAFE);
    check("simul overflow", 32'(overflow), 32'd0);

    // Asynchronous reset mid-word with a held word and overflow set.
    flush();
    word_ready = 1'b0; collect_en = 1'b1; sync_valid = 1'b1;
    feed_word(32'h0F0F0F0F, 32);
    feed_word(32'hF0F0F0F0, 32);
    feed_word(32'hAAAAAAAA, 5);
    check("pre-rst overflow", 32'(overflow), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst word_valid", 32'(word_valid), 32'd0);
    check("arst word_data", word_data, 32'h0);
    check("arst overflow", 32'(overflow), 32'd0);
    #2 rst_n = 1'b1;
    feed_word(32'hFFFFFFFF, 31);
    check("post-rst no early word", 32'(word_valid), 32'd0);
    sync_data = 1'b1;
    tick();
    check("post-rst valid", 32'(word_valid), 32'd1);
    check("post-rst word", word_data, 32'hFFFFFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
